// File: rtl/ahbl_to_apb.sv
// ahbl_to_apb: AHB-Lite slave to APB master bridge, one outstanding transfer.
// Optional macro AHBL_TO_APB_PSLVERR_EN maps APB slave errors onto a two-cycle AHB ERROR response.
module ahbl_to_apb #(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ahbls_hready,
  output logic               ahbls_hready_resp,
  output logic               ahbls_hresp,
  input  logic [W_HADDR-1:0] ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [2:0]         ahbls_hburst,
  input  logic [3:0]         ahbls_hprot,
  input  logic               ahbls_hmastlock,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,
  output logic [W_PADDR-1:0] apbm_paddr,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [W_DATA-1:0]  apbm_pwdata,
  input  logic [W_DATA-1:0]  apbm_prdata,
  input  logic               apbm_pready,
  input  logic               apbm_pslverr
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_WAIT = 3'd1,
    S_SETUP   = 3'd2,
    S_ACCESS  = 3'd3,
    S_ERR0    = 3'd4,
    S_ERR1    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [W_PADDR-1:0] paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [W_DATA-1:0]  pwdata_q, pwdata_d;
  logic               accept_s;
  logic               slverr_s;
  logic               done_s;
  logic               unused_s;

  assign accept_s = ahbls_hready & ahbls_htrans[1];

`ifdef AHBL_TO_APB_PSLVERR_EN
  assign slverr_s    = apbm_pslverr;
  assign ahbls_hresp = (state_q == S_ERR0) || (state_q == S_ERR1);
  assign unused_s    = ^{ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                         ahbls_haddr, ahbls_htrans[0]};
`else
  assign slverr_s    = 1'b0;
  assign ahbls_hresp = 1'b0;
  assign unused_s    = ^{ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                         ahbls_haddr, ahbls_htrans[0], apbm_pslverr};
`endif

  // Next-state and address/data capture; done_s marks a cycle that can take a new address phase.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    done_s   = 1'b0;
    case (state_q)
      S_IDLE:    done_s = 1'b1;
      S_ERR1:    done_s = 1'b1;
      S_WR_WAIT: begin
        pwdata_d = ahbls_hwdata;
        state_d  = S_SETUP;
      end
      S_SETUP:   state_d = S_ACCESS;
      S_ACCESS: begin
        if (apbm_pready && slverr_s) begin
          state_d = S_ERR0;
        end else if (apbm_pready) begin
          done_s = 1'b1;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_ERR0:    state_d = S_ERR1;
      default:   state_d = S_IDLE;
    endcase
    // Accepting in the completing cycle chains the next transfer without an IDLE gap.
    if (done_s) begin
      if (accept_s) begin
        paddr_d  = ahbls_haddr[W_PADDR-1:0];
        pwrite_d = ahbls_hwrite;
        state_d  = ahbls_hwrite ? S_WR_WAIT : S_SETUP;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      state_d = state_d;
    end
  end

  // State and APB request registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
    end
  end

  assign ahbls_hready_resp = done_s;
  assign ahbls_hrdata      = apbm_prdata;
  assign apbm_psel         = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign apbm_penable      = (state_q == S_ACCESS);
  assign apbm_paddr        = paddr_q;
  assign apbm_pwrite       = pwrite_q;
  assign apbm_pwdata       = pwdata_q;

endmodule

// File: tb/tb_ahbl_to_apb.sv
// Self-checking bench for ahbl_to_apb: directed cases plus random transfers against a timeline model.
module tb_ahbl_to_apb;
  localparam int W_HADDR = 32;
  localparam int W_PADDR = 16;
  localparam int W_DATA  = 32;
`ifdef AHBL_TO_APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               ahbls_hready, ahbls_hready_resp, ahbls_hresp, ahbls_hwrite;
  logic [W_HADDR-1:0] ahbls_haddr;
  logic [1:0]         ahbls_htrans;
  logic [2:0]         ahbls_hsize, ahbls_hburst;
  logic [3:0]         ahbls_hprot;
  logic               ahbls_hmastlock;
  logic [W_DATA-1:0]  ahbls_hwdata, ahbls_hrdata;
  logic [W_PADDR-1:0] apbm_paddr;
  logic               apbm_psel, apbm_penable, apbm_pwrite, apbm_pready, apbm_pslverr;
  logic [W_DATA-1:0]  apbm_pwdata, apbm_prdata;

  int checks = 0;
  int errors = 0;

  ahbl_to_apb #(.W_HADDR(W_HADDR), .W_PADDR(W_PADDR), .W_DATA(W_DATA)) dut (
    .clk(clk), .rst_n(rst_n),
    .ahbls_hready(ahbls_hready), .ahbls_hready_resp(ahbls_hready_resp), .ahbls_hresp(ahbls_hresp),
    .ahbls_haddr(ahbls_haddr), .ahbls_hwrite(ahbls_hwrite), .ahbls_htrans(ahbls_htrans),
    .ahbls_hsize(ahbls_hsize), .ahbls_hburst(ahbls_hburst), .ahbls_hprot(ahbls_hprot),
    .ahbls_hmastlock(ahbls_hmastlock), .ahbls_hwdata(ahbls_hwdata), .ahbls_hrdata(ahbls_hrdata),
    .apbm_paddr(apbm_paddr), .apbm_psel(apbm_psel), .apbm_penable(apbm_penable),
    .apbm_pwrite(apbm_pwrite), .apbm_pwdata(apbm_pwdata), .apbm_prdata(apbm_prdata),
    .apbm_pready(apbm_pready), .apbm_pslverr(apbm_pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle with no transfer in flight: bridge must be idle and ready.
  task automatic idle_cycle(input logic [1:0] trans, input logic rdy);
    @(negedge clk);
    ahbls_htrans = trans;
    ahbls_hready = rdy;
    ahbls_haddr  = $urandom;
    ahbls_hwrite = 1'($urandom);
    apbm_pready  = 1'($urandom);
    apbm_prdata  = $urandom;
    #1;
    chk("idle_psel", {31'd0, apbm_psel}, 32'd0);
    chk("idle_penable", {31'd0, apbm_penable}, 32'd0);
    chk("idle_hready_resp", {31'd0, ahbls_hready_resp}, 32'd1);
    chk("idle_hresp", {31'd0, ahbls_hresp}, 32'd0);
  endtask

  // Address phase issued while the bridge is idle.
  task automatic addr_idle(input logic [31:0] addr, input logic wr);
    @(negedge clk);
    ahbls_htrans = 2'b10;
    ahbls_hready = 1'b1;
    ahbls_haddr  = addr;
    ahbls_hwrite = wr;
    apbm_pready  = 1'($urandom);
    #1;
    chk("addr_psel", {31'd0, apbm_psel}, 32'd0);
    chk("addr_hready_resp", {31'd0, ahbls_hready_resp}, 32'd1);
  endtask

  // Data phase of one transfer, checked cycle by cycle against the protocol timeline:
  // optional write-data cycle, SETUP, ACCESS (+nwait), optional two error cycles.
  task automatic data_phase(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [31:0] rd, input int nwait, input logic err,
                            input logic nxt_v, input logic [31:0] nxt_a, input logic nxt_w);
    int o, acc_last, len;
    logic err_eff, exp_sel, exp_en;
    o        = wr ? 1 : 0;
    acc_last = o + 1 + nwait;
    err_eff  = err && ERR_EN;
    len      = acc_last + 1 + (err_eff ? 2 : 0);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      ahbls_hwdata = (wr && k == 0) ? wd : $urandom;
      apbm_prdata  = (k == acc_last) ? rd : $urandom;
      apbm_pready  = (k == acc_last) ? 1'b1 : ((k > o && k < acc_last) ? 1'b0 : 1'($urandom));
      apbm_pslverr = (k == acc_last) ? err : 1'($urandom);
      if (k == len - 1 && nxt_v) begin
        ahbls_htrans = {1'b1, 1'($urandom)};
        ahbls_hready = 1'b1;
        ahbls_haddr  = nxt_a;
        ahbls_hwrite = nxt_w;
      end else if (k == len - 1) begin
        ahbls_htrans = {1'b0, 1'($urandom)};
        ahbls_hready = 1'b1;
        ahbls_haddr  = $urandom;
      end else begin
        ahbls_htrans = 2'($urandom);
        ahbls_hready = 1'b0;
        ahbls_haddr  = $urandom;
      end
      #1;
      exp_sel = (k >= o) && (k <= acc_last);
      exp_en  = (k > o) && (k <= acc_last);
      chk("psel", {31'd0, apbm_psel}, {31'd0, exp_sel});
      chk("penable", {31'd0, apbm_penable}, {31'd0, exp_en});
      chk("hready_resp", {31'd0, ahbls_hready_resp}, {31'd0, (k == len - 1)});
      chk("hresp", {31'd0, ahbls_hresp}, {31'd0, (err_eff && k >= len - 2)});
      chk("hrdata", ahbls_hrdata, apbm_prdata);
      if (exp_sel) begin
        chk("paddr", {16'd0, apbm_paddr}, {16'd0, addr[15:0]});
        chk("pwrite", {31'd0, apbm_pwrite}, {31'd0, wr});
        if (wr) chk("pwdata", apbm_pwdata, wd);
      end
    end
  endtask

  logic [31:0] cur_a, cur_d, nxt_a, nxt_d;
  logic        cur_w, cur_e, nxt_w, nxt_e, b2b;
  int          cur_n, nxt_n;

  initial begin
    rst_n = 1'b0;
    ahbls_hready = 1'b0; ahbls_haddr = '0; ahbls_hwrite = 1'b0; ahbls_htrans = 2'b00;
    ahbls_hsize = 3'b010; ahbls_hburst = 3'b000; ahbls_hprot = 4'b0011; ahbls_hmastlock = 1'b0;
    ahbls_hwdata = '0; apbm_prdata = '0; apbm_pready = 1'b1; apbm_pslverr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_psel", {31'd0, apbm_psel}, 32'd0);
    chk("rst_penable", {31'd0, apbm_penable}, 32'd0);
    chk("rst_paddr", {16'd0, apbm_paddr}, 32'd0);
    chk("rst_pwrite", {31'd0, apbm_pwrite}, 32'd0);
    chk("rst_pwdata", apbm_pwdata, 32'd0);
    chk("rst_hready_resp", {31'd0, ahbls_hready_resp}, 32'd1);
    chk("rst_hresp", {31'd0, ahbls_hresp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle(2'b00, 1'b1);

    // Directed: simple read, waited write, back-to-back read then write.
    addr_idle(32'h4000_0010, 1'b0);
    data_phase(32'h4000_0010, 1'b0, 32'd0, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 32'd0, 1'b0);
    addr_idle(32'h0000_1234, 1'b1);
    data_phase(32'h0000_1234, 1'b1, 32'hDEAD_BEEF, 32'd0, 3, 1'b0, 1'b0, 32'd0, 1'b0);
    addr_idle(32'h0000_0100, 1'b0);
    data_phase(32'h0000_0100, 1'b0, 32'd0, 32'h1111_2222, 1, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    data_phase(32'h0000_0200, 1'b1, 32'h3333_4444, 32'd0, 0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Directed: slave error on a write, followed back-to-back by a read.
    addr_idle(32'h0000_0300, 1'b1);
    data_phase(32'h0000_0300, 1'b1, 32'h5555_6666, 32'd0, 0, 1'b1, 1'b1, 32'h0000_0304, 1'b0);
    data_phase(32'h0000_0304, 1'b0, 32'd0, 32'h7777_8888, 0, 1'b0, 1'b0, 32'd0, 1'b0);

    // BUSY and un-ready NONSEQ must not start a transfer.
    idle_cycle(2'b01, 1'b1);
    idle_cycle(2'b10, 1'b0);
    idle_cycle(2'b11, 1'b0);
    idle_cycle(2'b00, 1'b1);

    // Random transfers with random waits, errors and back-to-back chaining.
    cur_a = $urandom; cur_w = 1'($urandom); cur_d = $urandom;
    cur_n = $urandom_range(0, 3); cur_e = ($urandom_range(0, 3) == 0);
    addr_idle(cur_a, cur_w);
    for (int i = 0; i < 60; i++) begin
      nxt_a = $urandom; nxt_w = 1'($urandom); nxt_d = $urandom;
      nxt_n = $urandom_range(0, 3); nxt_e = ($urandom_range(0, 3) == 0);
      b2b   = (i < 59) && 1'($urandom);
      data_phase(cur_a, cur_w, cur_d, $urandom, cur_n, cur_e, b2b, nxt_a, nxt_w);
      if (!b2b && i < 59) begin
        idle_cycle({1'b0, 1'($urandom)}, 1'($urandom));
        addr_idle(nxt_a, nxt_w);
      end
      cur_a = nxt_a; cur_w = nxt_w; cur_d = nxt_d; cur_n = nxt_n; cur_e = nxt_e;
    end
    idle_cycle(2'b00, 1'b1);

    // Reset asserted while in ACCESS drops psel/penable without a clock edge.
    addr_idle(32'h0000_0400, 1'b0);
    @(negedge clk);
    ahbls_htrans = 2'b00; ahbls_hready = 1'b0; apbm_pready = 1'b0;
    @(negedge clk);
    apbm_pready = 1'b0;
    #1;
    chk("pre_rst_penable", {31'd0, apbm_penable}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_psel", {31'd0, apbm_psel}, 32'd0);
    chk("async_rst_penable", {31'd0, apbm_penable}, 32'd0);
    chk("async_rst_hready_resp", {31'd0, ahbls_hready_resp}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle(2'b00, 1'b1);
    addr_idle(32'h0000_0500, 1'b0);
    data_phase(32'h0000_0500, 1'b0, 32'd0, 32'h9999_AAAA, 2, 1'b0, 1'b0, 32'd0, 1'b0);
    idle_cycle(2'b00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbl_to_apb.md
AHBL_TO_APB -- requirements
Module: ahbl_to_apb

Interface
REQ-001 SHALL have parameter W_HADDR, default 32, AHB address width.
REQ-002 SHALL have parameter W_PADDR, default 16, APB address width (W_PADDR <= W_HADDR).
REQ-003 SHALL have parameter W_DATA, default 32, data width on both buses.
REQ-004 SHALL have ports, one per line: name  direction  width  meaning:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ahbls_hready  in  1  fabric HREADY; address phase valid when high
- ahbls_hready_resp  out  1  data-phase completion to fabric
- ahbls_hresp  out  1  error response
- ahbls_haddr  in  W_HADDR  address
- ahbls_hwrite  in  1  write select
- ahbls_htrans  in  2  transfer type
- ahbls_hsize  in  3  size, ignored
- ahbls_hburst  in  3  burst, ignored
- ahbls_hprot  in  4  protection, ignored
- ahbls_hmastlock  in  1  lock, ignored
- ahbls_hwdata  in  W_DATA  write data
- ahbls_hrdata  out  W_DATA  read data
- apbm_paddr  out  W_PADDR  APB address
- apbm_psel  out  1  APB select
- apbm_penable  out  1  APB enable
- apbm_pwrite  out  1  APB direction
- apbm_pwdata  out  W_DATA  APB write data
- apbm_prdata  in  W_DATA  APB read data
- apbm_pready  in  1  APB wait/complete
- apbm_pslverr  in  1  APB error

Function
REQ-005 SHALL accept a transfer when ahbls_hready=1 and ahbls_htrans[1]=1; SHALL latch haddr[W_PADDR-1:0] into paddr and hwrite into pwrite.
REQ-006 SHALL implement states IDLE, WR_WAIT, SETUP, ACCESS, ERR0, ERR1.
REQ-007 On accept, from IDLE, from ACCESS with pready=1, or from ERR1: read -> SETUP, write -> WR_WAIT.
REQ-008 If no accept occurs, those same transitions SHALL go to IDLE; IDLE and IDLE/BUSY htrans SHALL cause no APB activity.
REQ-009 WR_WAIT SHALL last one cycle, register ahbls_hwdata into pwdata, then go to SETUP.
REQ-010 SETUP SHALL drive psel=1, penable=0, and go to ACCESS.
REQ-011 ACCESS SHALL drive psel=1, penable=1, and hold until pready=1; paddr, pwrite and pwdata SHALL be stable from SETUP through ACCESS.
REQ-012 ahbls_hready_resp SHALL be 1 in IDLE and ERR1, 1 in ACCESS when pready=1 with no error taken, and 0 otherwise.
REQ-013 ahbls_hrdata SHALL equal apbm_prdata combinationally; it is valid only in the completing ACCESS cycle.
REQ-014 Minimum data-phase latency: read 2 cycles, write 3 cycles; each APB wait state adds one cycle.
REQ-015 Back-to-back transfers accepted in the completing cycle SHALL enter SETUP/WR_WAIT with no IDLE gap.
REQ-016 The block SHALL NOT generate pstrb; sub-word writes pass full pwdata.

Reset
REQ-017 On rst_n low: state=IDLE, hready_resp=1, hresp=0, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0.
REQ-018 Reset asserted mid-transfer SHALL abort the APB transfer immediately, with psel and penable low asynchronously.

Configuration
REQ-019 Macro AHBL_TO_APB_PSLVERR_EN defined: ACCESS with pready=1 and pslverr=1 -> ERR0 (hresp=1, hready_resp=0) -> ERR1 (hresp=1, hready_resp=1); accepts are sampled in ERR1 per REQ-007.
REQ-020 Macro undefined: pslverr SHALL be ignored, hresp tied 0, and ERR0/ERR1 unreachable.

Verification
REQ-021 Read 0x4000_0010, pready=1, prdata=0xCAFEF00D -> paddr=0x0010, psel for 2 cycles, hready_resp low 1 cycle, hrdata=0xCAFEF00D.
REQ-022 Write 0x1234 of 0xDEADBEEF, pready low 3 cycles -> pwdata=0xDEADBEEF stable in SETUP/ACCESS, hready_resp low 5 cycles.
REQ-023 Read then write back-to-back -> second SETUP/WR_WAIT directly follows completing ACCESS, with no IDLE cycle.
REQ-024 pslverr=1 on write with macro defined -> hresp=1 for 2 cycles, hready_resp 0 then 1; without macro -> hresp=0 and normal completion.
REQ-025 rst_n low in ACCESS -> psel=penable=0 immediately; after release, hready_resp=1 and a new read completes normally.
REQ-026 htrans=BUSY, or htrans=NONSEQ with hready=0 -> psel stays 0.
